// File: rtl/uart_pkg.sv
// Shared types, line levels and parity helper for the UART transmit/receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Parity over 7 or 8 data bits; odd = 1 inverts the even-parity result.
   function automatic logic calc_parity(input logic [7:0] data,
                                        input logic       eight,
                                        input logic       odd);
      logic p;
      p = ^data[6:0];
      if (eight) begin
         p = p ^ data[7];
      end
      return p ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter: one-cycle bit_tick_o every (reload+1) clocks while enabled.
// Latency: first tick (div_i+1) clocks after load_i; reload value captured at load_i.
// Backpressure: none; the consumer must act on every tick.
// Ports:
//   clk, reset     clock, async active-low reset
//   load_i, div_i  restart the count and capture div_i as the period reload value
//   en_i           counting enable (count holds while low)
//   bit_tick_o     one-cycle pulse at the last clock of each bit period
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             en_i,
   output logic             bit_tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] reload_q, reload_d;

   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      if (load_i) begin
         reload_d = div_i;
         cnt_d    = div_i;
      end else if (en_i) begin
         // Auto-reload keeps consecutive bits exactly reload+1 clocks long.
         if (cnt_q == '0) begin
            cnt_d = reload_q;
         end else begin
            cnt_d = cnt_q - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         reload_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
      end
   end

   assign bit_tick_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises start, 7/8 data bits LSB first, optional parity, stop.
// Latency: tx/tx_rdy change one clock after an accepted wr; tx_done one clock after the stop bit.
// Backpressure: tx_rdy low while a frame is in flight; a wr then is dropped and flags tx_ovr.
// Ports:
//   clk, reset               clock, async active-low reset
//   wr, din                  one-cycle write strobe and byte to send
//   baud_div, eight, pen,    frame config, captured on the accepted wr
//   ohel
//   ovr_clr                  clears the sticky overrun flag
//   tx                       serial line (idle high), registered
//   tx_rdy, tx_done, tx_ovr  ready flag, end-of-frame pulse, sticky overrun
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr,
   input  logic [7:0]       din,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             eight,
   input  logic             pen,
   input  logic             ohel,
   input  logic             ovr_clr,
   output logic             tx,
   output logic             tx_rdy,
   output logic             tx_done,
   output logic             tx_ovr
);

   tx_state_t  state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       eight_q, eight_d;
   logic       pen_q, pen_d;
   logic       par_q, par_d;
   logic       tx_q, tx_d;
   logic       rdy_q, rdy_d;
   logic       done_q, done_d;
   logic       ovr_q, ovr_d;

   logic             accept;
   logic             bit_tick;
   logic             baud_en;
   logic [DIV_W-1:0] div_eff;
   logic [2:0]       last_bit;

   // A divisor of 0 would give 1-clock bits; clamp so the shortest bit is 2 clocks.
   assign div_eff  = (baud_div == '0) ? DIV_W'(1) : baud_div;
   assign accept   = wr && rdy_q;
   assign baud_en  = (state_q != ST_IDLE);
   assign last_bit = eight_q ? 3'd7 : 3'd6;

   uart_baud_gen #(
      .DIV_W (DIV_W)
   ) u_baud_gen (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept),
      .div_i      (div_eff),
      .en_i       (baud_en),
      .bit_tick_o (bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      eight_d   = eight_q;
      pen_d     = pen_q;
      par_d     = par_q;
      tx_d      = tx_q;
      rdy_d     = rdy_q;
      done_d    = 1'b0;
      ovr_d     = ovr_q;

      // Overrun set beats a same-cycle clear.
      if (wr && !rdy_q) begin
         ovr_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_d = 1'b0;
      end

      // tx_d is the level for the upcoming bit, so tx stays a plain register.
      unique case (state_q)
         ST_IDLE: begin
            tx_d = IDLE_LEVEL;
            if (accept) begin
               shreg_d   = din;
               eight_d   = eight;
               pen_d     = pen;
               par_d     = calc_parity(din, eight, ohel);
               bit_cnt_d = 3'd0;
               rdy_d     = 1'b0;
               tx_d      = START_BIT;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               tx_d      = shreg_q[0];
               bit_cnt_d = 3'd0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_cnt_q == last_bit) begin
                  if (pen_q) begin
                     tx_d    = par_q;
                     state_d = ST_PARITY;
                  end else begin
                     tx_d    = STOP_BIT;
                     state_d = ST_STOP;
                  end
               end else begin
                  shreg_d   = {1'b0, shreg_q[7:1]};
                  tx_d      = shreg_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               tx_d    = STOP_BIT;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               tx_d      = IDLE_LEVEL;
               rdy_d     = 1'b1;
               done_d    = 1'b1;
               bit_cnt_d = 3'd0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            tx_d    = IDLE_LEVEL;
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         eight_q   <= 1'b0;
         pen_q     <= 1'b0;
         par_q     <= 1'b0;
         tx_q      <= IDLE_LEVEL;
         rdy_q     <= 1'b1;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         eight_q   <= eight_d;
         pen_q     <= pen_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         rdy_q     <= rdy_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
      end
   end

   assign tx      = tx_q;
   assign tx_rdy  = rdy_q;
   assign tx_done = done_q;
   assign tx_ovr  = ovr_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: queue-based line model plus directed literal checks.
module tb_uart_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  din = 8'h00;
   logic [15:0] baud_div = 16'd3;
   logic        eight = 1'b1;
   logic        pen = 1'b0;
   logic        ohel = 1'b0;
   logic        ovr_clr = 1'b0;
   logic        tx, tx_rdy, tx_done, tx_ovr;

   int n_chk = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DIV_W(16)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .wr       (wr),
      .din      (din),
      .baud_div (baud_div),
      .eight    (eight),
      .pen      (pen),
      .ohel     (ohel),
      .ovr_clr  (ovr_clr),
      .tx       (tx),
      .tx_rdy   (tx_rdy),
      .tx_done  (tx_done),
      .tx_ovr   (tx_ovr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model: the frame is a queue of line levels ----------------
   logic m_tx = 1'b1, m_rdy = 1'b1, m_done = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
   logic mq[$];
   int   m_bitlen, m_nbits;
   logic m_par, m_prev_rdy;
   logic m_bits[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_tx = 1'b1; m_rdy = 1'b1; m_done = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      end else begin
         m_prev_rdy = m_rdy;
         m_done = 1'b0;
         if (wr && !m_prev_rdy) m_ovr = 1'b1;
         else if (ovr_clr)      m_ovr = 1'b0;
         if (wr && m_prev_rdy) begin
            m_bitlen = (baud_div == 16'd0) ? 2 : int'(baud_div) + 1;
            m_nbits  = eight ? 8 : 7;
            m_bits.delete();
            m_bits.push_back(1'b0);
            m_par = ohel;
            for (int i = 0; i < m_nbits; i++) begin
               m_bits.push_back(din[i]);
               m_par = m_par ^ din[i];
            end
            if (pen) m_bits.push_back(m_par);
            m_bits.push_back(1'b1);
            foreach (m_bits[b])
               for (int r = 0; r < m_bitlen; r++) mq.push_back(m_bits[b]);
            m_busy = 1'b1;
            m_rdy  = 1'b0;
            m_tx   = mq.pop_front();
         end else if (mq.size() > 0) begin
            m_tx = mq.pop_front();
         end else if (m_busy) begin
            m_busy = 1'b0; m_rdy = 1'b1; m_done = 1'b1; m_tx = 1'b1;
         end else begin
            m_tx = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("tx", {31'd0, tx}, {31'd0, m_tx});
         chk("tx_rdy", {31'd0, tx_rdy}, {31'd0, m_rdy});
         chk("tx_done", {31'd0, tx_done}, {31'd0, m_done});
         chk("tx_ovr", {31'd0, tx_ovr}, {31'd0, m_ovr});
      end
   end

   // ---------------- directed helpers ----------------
   logic tr_tx[64], tr_rdy[64], tr_done[64], tr_ovr[64];

   // Called at a negedge with the DUT idle; that cycle is cycle 0 (the wr cycle).
   task automatic run_frame(input logic [7:0] d, input logic [15:0] bd, input logic e, p, o,
                            input logic [7:0] d2, input logic [63:0] wr_m, clr_m,
                            input int bd_at, input logic [15:0] bd2, input int ncyc);
      din = d; baud_div = bd; eight = e; pen = p; ohel = o; wr = 1'b1; ovr_clr = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         tr_tx[k] = tx; tr_rdy[k] = tx_rdy; tr_done[k] = tx_done; tr_ovr[k] = tx_ovr;
         wr = wr_m[k]; ovr_clr = clr_m[k];
         if (wr_m[k]) din = d2;
         if (k == bd_at) baud_div = bd2;
      end
      wr = 1'b0; ovr_clr = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(tx_rdy && !tx_done) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("idle_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   // 0x55, 8N1, 4-clock bits: line alternates 0,1,0,... per bit over cycles 1..40.
   task automatic chk_55(input string nm);
      for (int c = 1; c <= 40; c++)
         chk(nm, {31'd0, tr_tx[c]}, ((c - 1) / 4) % 2);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_rdy", {31'd0, tx_rdy}, 32'd1);
      chk("rst_done", {31'd0, tx_done}, 32'd0);
      chk("rst_ovr", {31'd0, tx_ovr}, 32'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // Basic 8N1 frame with a back-to-back write (0x0F) in the tx_done cycle.
      run_frame(8'h55, 16'd3, 1'b1, 1'b0, 1'b0, 8'h0F, 64'd1 << 41, 64'd0, 0, 16'd0, 50);
      chk_55("b_tx");
      chk("b_rdy40", {31'd0, tr_rdy[40]}, 32'd0);
      chk("b_done40", {31'd0, tr_done[40]}, 32'd0);
      chk("b_done41", {31'd0, tr_done[41]}, 32'd1);
      chk("b_rdy41", {31'd0, tr_rdy[41]}, 32'd1);
      chk("b2b_idle41", {31'd0, tr_tx[41]}, 32'd1);
      chk("b2b_start42", {31'd0, tr_tx[42]}, 32'd0);
      chk("b2b_start45", {31'd0, tr_tx[45]}, 32'd0);
      chk("b2b_bit0_46", {31'd0, tr_tx[46]}, 32'd1);
      wait_idle();

      // 7E1 on 0xC1: data 0x41 has two ones, parity 0; bit 7 never sent.
      run_frame(8'hC1, 16'd3, 1'b0, 1'b1, 1'b0, 8'h00, 64'd0, 64'd0, 0, 16'd0, 42);
      chk("p7_bit5", {31'd0, tr_tx[25]}, 32'd0);
      chk("p7_bit6", {31'd0, tr_tx[30]}, 32'd1);
      chk("pe_par", {31'd0, tr_tx[34]}, 32'd0);
      chk("pe_stop", {31'd0, tr_tx[37]}, 32'd1);
      chk("pe_done40", {31'd0, tr_done[40]}, 32'd0);
      chk("pe_done41", {31'd0, tr_done[41]}, 32'd1);
      wait_idle();

      // 7O1 on 0xC1: parity 1.
      run_frame(8'hC1, 16'd3, 1'b0, 1'b1, 1'b1, 8'h00, 64'd0, 64'd0, 0, 16'd0, 42);
      chk("po_par", {31'd0, tr_tx[34]}, 32'd1);
      chk("po_done41", {31'd0, tr_done[41]}, 32'd1);
      wait_idle();

      // Overrun: 0xAA at cycle 10, wr+clr at 15 (set wins), clr alone at 20.
      run_frame(8'h55, 16'd3, 1'b1, 1'b0, 1'b0, 8'hAA, (64'd1 << 10) | (64'd1 << 15),
                (64'd1 << 15) | (64'd1 << 20), 0, 16'd0, 42);
      chk_55("ovr_tx");
      chk("ovr10", {31'd0, tr_ovr[10]}, 32'd0);
      chk("ovr11", {31'd0, tr_ovr[11]}, 32'd1);
      chk("ovr16", {31'd0, tr_ovr[16]}, 32'd1);
      chk("ovr20", {31'd0, tr_ovr[20]}, 32'd1);
      chk("ovr21", {31'd0, tr_ovr[21]}, 32'd0);
      chk("ovr_done41", {31'd0, tr_done[41]}, 32'd1);
      wait_idle();

      // baud_div 0 -> 2-clock bits; a mid-frame divisor change is ignored.
      run_frame(8'h55, 16'd0, 1'b1, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 3, 16'd9, 24);
      chk("d0_1", {31'd0, tr_tx[1]}, 32'd0);
      chk("d0_2", {31'd0, tr_tx[2]}, 32'd0);
      chk("d0_3", {31'd0, tr_tx[3]}, 32'd1);
      chk("d0_4", {31'd0, tr_tx[4]}, 32'd1);
      chk("d0_5", {31'd0, tr_tx[5]}, 32'd0);
      chk("d0_done20", {31'd0, tr_done[20]}, 32'd0);
      chk("d0_done21", {31'd0, tr_done[21]}, 32'd1);
      wait_idle();

      // Reset during DATA of an all-zero byte, with overrun set beforehand.
      run_frame(8'h00, 16'd3, 1'b1, 1'b0, 1'b0, 8'hFF, 64'd1 << 5, 64'd0, 0, 16'd0, 15);
      chk("pre_rst_tx", {31'd0, tr_tx[15]}, 32'd0);
      chk("pre_rst_ovr", {31'd0, tr_ovr[15]}, 32'd1);
      #2;
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_tx", {31'd0, tx}, 32'd1);
      chk("arst_rdy", {31'd0, tx_rdy}, 32'd1);
      chk("arst_ovr", {31'd0, tx_ovr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      run_frame(8'h55, 16'd3, 1'b1, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0, 0, 16'd0, 42);
      chk_55("post_rst_tx");
      chk("post_rst_done41", {31'd0, tr_done[41]}, 32'd1);
      wait_idle();

      // Randomised traffic: config and divisor churn every cycle; model decides what is sent.
      for (int c = 0; c < 3000; c++) begin
         wr       = ($urandom_range(0, 7) == 0);
         din      = 8'($urandom);
         eight    = 1'($urandom);
         pen      = 1'($urandom);
         ohel     = 1'($urandom);
         baud_div = 16'($urandom_range(0, 4));
         ovr_clr  = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      wr = 1'b0;
      ovr_clr = 1'b0;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
